// File: rtl/adder_check_pkg.sv
// adder_check_pkg: shared FSM state type, default parameters and vector-width helper for the adder sweep checker
package adder_check_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_e;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SETTLE = 1;
  function automatic int vec_width(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/adder_result_check.sv
// adder_result_check: combinational reference sum of a+b+cin, flags mismatch against {cout,sum} from the adder under check
module adder_result_check
  import adder_check_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             mismatch
);
  logic [WIDTH:0] exp_sum;
  always_comb begin
    exp_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    mismatch = exp_sum != {cout, sum};
  end
endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: drives every {a,b,cin} into an external adder, samples {cout,sum} after SETTLE cycles, reports pass, error count and first failing vector
module adder_sweep_checker
  import adder_check_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output logic                   cin,
  input  logic [WIDTH-1:0]       sum,
  input  logic                   cout,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2*WIDTH+1:0]     err_count,
  output logic                   fail_valid,
  output logic [2*WIDTH:0]       first_fail
);
  localparam int VW = vec_width(WIDTH);
  localparam int CW = 2 * WIDTH + 2;
  localparam int WW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_e state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [VW-1:0] ff_q, ff_d;
  logic [CW-1:0] err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;
  logic fv_q, fv_d;
  logic mismatch;
  logic settled;
  assign {a, b, cin} = vec_q;
  assign settled = wait_q == WW'(SETTLE - 1);
  assign busy = state_q == APPLY || state_q == CHECK;
  assign done = state_q == FINISH;
  assign pass = done && err_q == '0;
  assign err_count = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;
  adder_result_check #(.WIDTH(WIDTH)) u_check (
    .a(a),
    .b(b),
    .cin(cin),
    .sum(sum),
    .cout(cout),
    .mismatch(mismatch)
  );
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    wait_d = wait_q;
    err_d = err_q;
    ff_d = ff_q;
    fv_d = fv_q;
    if ((state_q == IDLE || state_q == FINISH) && start) begin
      state_d = APPLY;
      vec_d = '0;
      wait_d = '0;
      err_d = '0;
      ff_d = '0;
      fv_d = 1'b0;
    end else if (state_q == APPLY) begin
      state_d = settled ? CHECK : APPLY;
      wait_d = settled ? '0 : wait_q + 1'b1;
    end else if (state_q == CHECK) begin
      if (mismatch) begin
        err_d = err_q + 1'b1;
        fv_d = 1'b1;
        ff_d = fv_q ? ff_q : vec_q;
      end
      // the last vector stays on the outputs while FINISH holds the verdict
      state_d = &vec_q ? FINISH : APPLY;
      vec_d = &vec_q ? vec_q : vec_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q <= '0;
      wait_q <= '0;
      err_q <= '0;
      ff_q <= '0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      wait_q <= wait_d;
      err_q <= err_d;
      ff_q <= ff_d;
      fv_q <= fv_d;
    end
  end
endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Synthesizable exhaustive stimulus/response engine for the `carry_lookahead` adder and any adder with the same A/B/CIN/SUM/COUT interface.
- Drives every operand/carry combination into the adder.
- Samples the adder's SUM/COUT after a programmable settle interval and compares them against an internal reference sum.
- Reports the pass/fail verdict, the error count and the first failing vector.
- Sits beside the adder in the lab top level, so adder correctness is checked on hardware without a simulator.

## Interface
- `WIDTH`, default 4: operand width of the adder under check.
- `SETTLE`, default 1: cycles each vector is held before sampling. Must be ≥1.
- `CLK` in, 1: single clock. All state is updated on its rising edge.
- `RST_N` in, 1: asynchronous, active-low reset.
- `START` in, 1: begin a sweep. Sampled only in IDLE or FINISH.
- `A` out, WIDTH: operand A to the adder.
- `B` out, WIDTH: operand B to the adder.
- `CIN` out, 1: carry-in to the adder.
- `SUM` in, WIDTH: adder sum result.
- `COUT` in, 1: adder carry-out.
- `BUSY` out, 1: high while a sweep is running.
- `DONE` out, 1: high in FINISH, held until the next START or reset.
- `PASS` out, 1: DONE and ERR_COUNT == 0.
- `ERR_COUNT` out, 2·WIDTH+2: number of mismatching vectors in the last sweep.
- `FAIL_VALID` out, 1: at least one mismatch has been captured.
- `FIRST_FAIL` out, 2·WIDTH+1: {A,B,CIN} of the first mismatching vector.

## Operation
- Vector counter `VEC` is 2·WIDTH+1 bits: {A,B,CIN} = VEC, with CIN as the LSB. The sweep runs from VEC = 0 to all-ones, covering every vector including A or B = 2^WIDTH−1.
- States:
  - IDLE:
    - START=1: clear VEC, ERR_COUNT, FAIL_VALID and FIRST_FAIL, then go to APPLY.
    - START=0: stay in IDLE.
  - APPLY: hold A/B/CIN from VEC. Stay SETTLE cycles using a wait counter, then go to CHECK.
  - CHECK: compare {COUT,SUM} against A+B+CIN computed at WIDTH+1 bits.
    - On mismatch, ERR_COUNT increments.
    - If FAIL_VALID=0 on that mismatch, capture FIRST_FAIL=VEC and set FAIL_VALID.
    - VEC all-ones: go to FINISH. Otherwise VEC+1 and go to APPLY.
  - FINISH: DONE=1 and results are held. START=1 behaves as in IDLE and restarts the sweep.
- BUSY = state ∈ {APPLY, CHECK}.
- START while BUSY is ignored.
- ERR_COUNT never overflows: the maximum is 2^(2·WIDTH+1).
- A, B and CIN keep their last value in FINISH. They return to 0 only on reset or a restart.

## Timing
- Reset value of every output is 0: A, B, CIN, BUSY, DONE, PASS, ERR_COUNT, FAIL_VALID, FIRST_FAIL. State resets to IDLE.
- Reset asserted mid-sweep aborts immediately. All outputs go to 0 asynchronously, with no partial verdict.
- START high at edge k (in IDLE): BUSY=1 and A=B=CIN=0 after edge k.
- Each vector occupies SETTLE+1 cycles: SETTLE in APPLY, 1 in CHECK. SUM/COUT are sampled at the CHECK edge.
- DONE rises 2^(2·WIDTH+1)·(SETTLE+1) cycles after the START edge. With the defaults this is 1024 cycles.
- A mismatch in CHECK is visible on ERR_COUNT/FIRST_FAIL the following cycle.
- PASS and DONE rise in the same cycle.

## Structure
- Shared package `adder_check_pkg`:
  - state enum {IDLE, APPLY, CHECK, FINISH}
  - default WIDTH/SETTLE localparams
  - vector-width function 2·WIDTH+1
- One sub-module is natural: `adder_result_check`.
  - Combinational reference sum plus mismatch flag.
  - Inputs: A, B, CIN, SUM, COUT. Output: `MISMATCH`.
  - Reusable by a future subtractor checker.
- The top level holds the FSM, VEC counter, wait counter, ERR_COUNT and FIRST_FAIL registers.

## Test plan
- Correct behavioral 4-bit adder, SETTLE=1, START pulse → DONE after 1024 cycles, PASS=1, ERR_COUNT=0, FAIL_VALID=0.
- SUM[0] stuck-at-0 → ERR_COUNT=256, FIRST_FAIL=9'h001 (A=0, B=0, CIN=1), PASS=0.
- COUT stuck-at-0 → ERR_COUNT=256, FIRST_FAIL=9'h01F (A=0, B=15, CIN=1).
- SETTLE=3, correct adder → DONE exactly 2048 cycles after START. A/B/CIN stable for 4 cycles per vector.
- Two cases during a sweep:
  - RST_N low at cycle 300 → all outputs 0 asynchronously.
  - After release, START restarts from VEC=0.
- START pulsed while BUSY → ignored, total latency unchanged. START in FINISH → new sweep with DONE low and ERR_COUNT cleared the next cycle.
